// File: rtl/tape_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tape_mem_arbiter
//
// Shares one byte-wide memory port between the tape-file loader (writes) and
// the tape reader (reads). Each side has a one-entry holding register; the
// FSM serves one access at a time and waits for a completion pulse, giving up
// after ACK_TIMEOUT wait cycles.
//
// Ports
//   clk_sys             system clock, everything on its rising edge
//   reset               synchronous, active-high
//   dl_active           loader download in progress (blocks reads)
//   dl_wr/addr/data     loader write strobe, byte address, byte
//   dl_wait             loader backpressure (write buffer occupied)
//   tp_req/tp_addr      tape-reader read strobe and address
//   tp_data/tp_valid    returned byte and its one-cycle qualifier
//   mem_addr/mem_din    memory command address and write byte
//   mem_we/mem_rd       one-cycle write / read command strobes
//   mem_dout/mem_ack    memory read byte and completion pulse
//   err                 sticky: some access timed out since reset
// -----------------------------------------------------------------------------
module tape_mem_arbiter #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    input  logic        tp_req,
    input  logic [24:0] tp_addr,
    output logic [7:0]  tp_data,
    output logic        tp_valid,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    // The wait counter is 8 bits wide, so ACK_TIMEOUT must lie in 1..255.
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_reg;
    state_t      state_next;

    logic        wr_pend_reg;
    logic [24:0] wr_addr_reg;
    logic [7:0]  wr_data_reg;

    logic        rd_pend_reg;
    logic [24:0] rd_addr_reg;

    logic        last_grant_wr_reg;   // 0 = read was granted last
    logic [7:0]  wait_cnt_reg;

    logic [24:0] mem_addr_reg;
    logic [7:0]  mem_din_reg;
    logic [7:0]  tp_data_reg;
    logic        tp_valid_reg;
    logic        err_reg;

    logic        rd_eligible;
    logic        grant_wr;
    logic        grant_rd;
    logic        wait_expired;

    // Arbitration only looks at the holding registers, so a request captured
    // on an edge is granted no earlier than the following edge.
    assign rd_eligible  = rd_pend_reg && !dl_active;
    assign grant_wr     = (state_reg == IDLE) && wr_pend_reg &&
                          (!rd_eligible || !last_grant_wr_reg);
    assign grant_rd     = (state_reg == IDLE) && rd_eligible &&
                          (!wr_pend_reg || last_grant_wr_reg);
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR_ISSUE;
                end else if (grant_rd) begin
                    state_next = RD_ISSUE;
                end
            end
            WR_ISSUE: state_next = WR_WAIT;
            WR_WAIT: begin
                // An ack on the last allowed wait cycle still counts.
                if (mem_ack || wait_expired) begin
                    state_next = IDLE;
                end
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT: begin
                if (mem_ack || wait_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_we   = (state_reg == WR_ISSUE);
        mem_rd   = (state_reg == RD_ISSUE);
        mem_addr = mem_addr_reg;
        mem_din  = mem_din_reg;
        dl_wait  = wr_pend_reg;
        tp_data  = tp_data_reg;
        tp_valid = tp_valid_reg;
        err      = err_reg;
    end

    // ---------------- buffers, command registers, wait counter ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_pend_reg       <= 1'b0;
            wr_addr_reg       <= '0;
            wr_data_reg       <= '0;
            rd_pend_reg       <= 1'b0;
            rd_addr_reg       <= '0;
            last_grant_wr_reg <= 1'b0;
            wait_cnt_reg      <= '0;
            mem_addr_reg      <= '0;
            mem_din_reg       <= '0;
            tp_data_reg       <= '0;
            tp_valid_reg      <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            tp_valid_reg <= 1'b0;

            // Capture only into an empty buffer; a buffer is emptied only by
            // a completing or aborting access, never on a capture edge.
            if (dl_wr && !wr_pend_reg) begin
                wr_pend_reg <= 1'b1;
                wr_addr_reg <= dl_addr;
                wr_data_reg <= dl_data;
            end
            if (tp_req && !rd_pend_reg) begin
                rd_pend_reg <= 1'b1;
                rd_addr_reg <= tp_addr;
            end

            case (state_reg)
                IDLE: begin
                    // Command registers load at grant and stay put until the
                    // next grant, covering the whole issue/wait window.
                    if (grant_wr) begin
                        mem_addr_reg      <= wr_addr_reg;
                        mem_din_reg       <= wr_data_reg;
                        last_grant_wr_reg <= 1'b1;
                    end else if (grant_rd) begin
                        mem_addr_reg      <= rd_addr_reg;
                        last_grant_wr_reg <= 1'b0;
                    end
                end
                WR_ISSUE, RD_ISSUE: begin
                    wait_cnt_reg <= '0;
                end
                WR_WAIT: begin
                    if (mem_ack) begin
                        wr_pend_reg <= 1'b0;
                    end else if (wait_expired) begin
                        wr_pend_reg <= 1'b0;
                        err_reg     <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        rd_pend_reg  <= 1'b0;
                        tp_data_reg  <= mem_dout;
                        tp_valid_reg <= 1'b1;
                    end else if (wait_expired) begin
                        // The reader is always answered, with a zero byte.
                        rd_pend_reg  <= 1'b0;
                        tp_data_reg  <= 8'h00;
                        tp_valid_reg <= 1'b1;
                        err_reg      <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_mem_arbiter.sv
module tb_tape_mem_arbiter;

    localparam int ACK_TIMEOUT = 64;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        tp_req;
    logic [24:0] tp_addr;
    logic [7:0]  tp_data;
    logic        tp_valid;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_rd;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        err;

    tape_mem_arbiter #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .tp_req    (tp_req),
        .tp_addr   (tp_addr),
        .tp_data   (tp_data),
        .tp_valid  (tp_valid),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    // cycle bookkeeping, updated by tick()
    int          cyc = 0;
    int          we_cnt = 0, rd_cnt = 0, tv_cnt = 0;
    int          last_we_cyc = -1, last_rd_cyc = -1, last_tv_cyc = -1;
    int          last_rd_ack_cyc = -1;
    logic [24:0] last_we_addr, last_rd_addr;
    logic [7:0]  last_we_data, last_tv_data;
    bit          obs_we, obs_rd, obs_tv, ack_wr_now;
    bit          grant_log[$];          // 1 = write command seen, 0 = read

    // memory responder state
    bit          resp_en = 1'b0;
    int unsigned ack_lo = 1, ack_hi = 1;
    bit          acc_pending = 1'b0;
    bit          acc_is_wr;
    logic [24:0] acc_addr;
    logic [7:0]  acc_data;
    int          acc_ack_cyc;
    logic [7:0]  mem_model [logic [24:0]];

    function automatic logic [7:0] rd_mem(input logic [24:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 8'h00;
    endfunction

    // Advance one cycle, record what the DUT shows in the new cycle and act
    // as the memory: ack a command a random 'ack_lo..ack_hi' cycles later.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        obs_we     = mem_we;
        obs_rd     = mem_rd;
        obs_tv     = tp_valid;
        ack_wr_now = 1'b0;
        mem_ack    = 1'b0;
        mem_dout   = 8'($urandom);
        if (mem_we) begin
            we_cnt++; last_we_cyc = cyc; last_we_addr = mem_addr; last_we_data = mem_din;
            grant_log.push_back(1'b1);
            acc_pending = 1'b1; acc_is_wr = 1'b1; acc_addr = mem_addr; acc_data = mem_din;
            acc_ack_cyc = cyc + int'($urandom_range(ack_hi, ack_lo));
            $display("[%0d] mem write addr=%h data=%h", cyc, mem_addr, mem_din);
        end
        if (mem_rd) begin
            rd_cnt++; last_rd_cyc = cyc; last_rd_addr = mem_addr;
            grant_log.push_back(1'b0);
            acc_pending = 1'b1; acc_is_wr = 1'b0; acc_addr = mem_addr;
            acc_ack_cyc = cyc + int'($urandom_range(ack_hi, ack_lo));
            $display("[%0d] mem read  addr=%h", cyc, mem_addr);
        end
        if (tp_valid) begin
            tv_cnt++; last_tv_cyc = cyc; last_tv_data = tp_data;
            $display("[%0d] tape byte data=%h", cyc, tp_data);
        end
        if (resp_en && acc_pending && cyc == acc_ack_cyc) begin
            mem_ack = 1'b1;
            if (acc_is_wr) begin
                mem_model[acc_addr] = acc_data;
                ack_wr_now = 1'b1;
            end else begin
                mem_dout = rd_mem(acc_addr);
                last_rd_ack_cyc = cyc;
            end
            acc_pending = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; dl_wr = 1'b0; tp_req = 1'b0; dl_active = 1'b0;
        acc_pending = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dl_wait  !== 1'b0)  begin failures++; $display("FAIL rst_dl_wait got=%b exp=0", dl_wait); end
        checks++; if (tp_valid !== 1'b0)  begin failures++; $display("FAIL rst_tp_valid got=%b exp=0", tp_valid); end
        checks++; if ({mem_we, mem_rd} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {mem_we, mem_rd}); end
        checks++; if (err      !== 1'b0)  begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (tp_data  !== 8'h00) begin failures++; $display("FAIL rst_tp_data got=%h exp=00", tp_data); end
        checks++; if (mem_addr !== 25'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_din  !== 8'h00) begin failures++; $display("FAIL rst_mem_din got=%h exp=00", mem_din); end
    endtask

    task automatic test_single_write();
        int c0, n_we, n_rd, nwait, first;
        do_reset();
        resp_en = 1'b1; ack_lo = 3; ack_hi = 3;
        n_we = we_cnt; n_rd = rd_cnt;
        dl_wr = 1'b1; dl_addr = 25'h000010; dl_data = 8'hA5; c0 = cyc;
        tick();
        nwait = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            if (dl_wait) begin nwait++; if (first < 0) first = cyc; end
            // a second write while backpressured must be dropped
            dl_wr = (i == 1); dl_addr = 25'h000099; dl_data = 8'h11;
            tick();
        end
        dl_wr = 1'b0;
        checks++; if (nwait !== 5)          begin failures++; $display("FAIL wr_wait_len got=%0d exp=5", nwait); end
        checks++; if (first !== c0 + 1)     begin failures++; $display("FAIL wr_wait_start got=%0d exp=%0d", first, c0 + 1); end
        checks++; if (we_cnt - n_we !== 1)  begin failures++; $display("FAIL wr_we_count got=%0d exp=1", we_cnt - n_we); end
        checks++; if (rd_cnt - n_rd !== 0)  begin failures++; $display("FAIL wr_rd_count got=%0d exp=0", rd_cnt - n_rd); end
        checks++; if (last_we_cyc !== c0 + 2) begin failures++; $display("FAIL wr_we_cycle got=%0d exp=%0d", last_we_cyc, c0 + 2); end
        checks++; if ({last_we_addr, last_we_data} !== {25'h000010, 8'hA5})
            begin failures++; $display("FAIL wr_cmd got=%h/%h exp=000010/a5", last_we_addr, last_we_data); end
    endtask

    task automatic test_single_read();
        int c0, n_rd, n_tv;
        do_reset();
        resp_en = 1'b1; ack_lo = 2; ack_hi = 2;
        mem_model[25'h000020] = 8'h3C;
        n_rd = rd_cnt; n_tv = tv_cnt;
        tp_req = 1'b1; tp_addr = 25'h000020; c0 = cyc;
        tick();
        tp_req = 1'b0; tp_addr = 25'h1ABCDEF;
        for (int i = 0; i < 30 && tv_cnt == n_tv; i++) tick();
        checks++; if (rd_cnt - n_rd !== 1)     begin failures++; $display("FAIL rd_count got=%0d exp=1", rd_cnt - n_rd); end
        checks++; if (last_rd_cyc !== c0 + 2)  begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", last_rd_cyc, c0 + 2); end
        checks++; if (last_rd_addr !== 25'h000020) begin failures++; $display("FAIL rd_addr got=%h exp=000020", last_rd_addr); end
        checks++; if (tv_cnt - n_tv !== 1)     begin failures++; $display("FAIL rd_tv_count got=%0d exp=1", tv_cnt - n_tv); end
        checks++; if (last_tv_cyc !== c0 + 5)  begin failures++; $display("FAIL rd_tv_cycle got=%0d exp=%0d", last_tv_cyc, c0 + 5); end
        checks++; if (last_tv_data !== 8'h3C)  begin failures++; $display("FAIL rd_data got=%h exp=3c", last_tv_data); end
        tick();
        checks++; if (tp_valid !== 1'b0)       begin failures++; $display("FAIL rd_tv_pulse got=%b exp=0", tp_valid); end
    endtask

    task automatic test_contention();
        bit          exp_first;
        int          n_tv;
        logic [24:0] ra;
        logic [7:0]  rv;
        do_reset();
        resp_en = 1'b1; ack_lo = 1; ack_hi = 4; dl_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                // a lone write makes "write" the last grant
                dl_wr = 1'b1; dl_addr = 25'h300; dl_data = 8'h33;
                tick();
                dl_wr = 1'b0;
                for (int i = 0; i < 40 && dl_wait; i++) tick();
            end
            exp_first = (k != 2);
            ra = 25'h200 + 25'(k); rv = 8'($urandom); mem_model[ra] = rv;
            grant_log.delete(); n_tv = tv_cnt;
            dl_wr = 1'b1; dl_addr = 25'h100 + 25'(k); dl_data = 8'($urandom);
            tp_req = 1'b1; tp_addr = ra;
            tick();
            dl_wr = 1'b0; tp_req = 1'b0;
            for (int i = 0; i < 60 && (grant_log.size() < 2 || dl_wait || tv_cnt == n_tv); i++) tick();
            checks++;
            if (grant_log.size() != 2) begin
                failures++; $display("FAIL cont_grants[%0d] got=%0d exp=2", k, grant_log.size());
            end else begin
                if (grant_log[0] !== exp_first || grant_log[1] !== !exp_first) begin
                    failures++; $display("FAIL cont_order[%0d] got=%b%b exp=%b%b (1=write)",
                                         k, grant_log[0], grant_log[1], exp_first, !exp_first);
                end
            end
            checks++; if (last_tv_data !== rv) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", k, last_tv_data, rv); end
        end
    endtask

    task automatic test_gating();
        int n_rd, n_we, f;
        do_reset();
        resp_en = 1'b1; ack_lo = 2; ack_hi = 2;
        dl_active = 1'b1;
        n_rd = rd_cnt;
        tp_req = 1'b1; tp_addr = 25'h000345;
        tick();
        tp_req = 1'b0;
        repeat (10) tick();
        checks++; if (rd_cnt !== n_rd) begin failures++; $display("FAIL gate_blocked got=%0d exp=0 reads", rd_cnt - n_rd); end
        dl_active = 1'b0; f = cyc;
        for (int i = 0; i < 10 && rd_cnt == n_rd; i++) tick();
        checks++;
        if (rd_cnt - n_rd !== 1 || last_rd_cyc - f < 1 || last_rd_cyc - f > 2) begin
            failures++; $display("FAIL gate_release reads=%0d delay=%0d exp reads=1 delay<=2", rd_cnt - n_rd, last_rd_cyc - f);
        end
        for (int i = 0; i < 20 && tp_valid == 1'b0; i++) tick();
        tick();
        // download ends while a write is in flight: the write still finishes
        ack_lo = 4; ack_hi = 4; n_we = we_cnt;
        dl_active = 1'b1;
        dl_wr = 1'b1; dl_addr = 25'h0000AB; dl_data = 8'h5E;
        tick();
        dl_wr = 1'b0;
        tick();
        dl_active = 1'b0;
        for (int i = 0; i < 20 && dl_wait; i++) tick();
        checks++; if (we_cnt - n_we !== 1 || last_we_addr !== 25'h0000AB || last_we_data !== 8'h5E)
            begin failures++; $display("FAIL dlfall_write count=%0d cmd=%h/%h exp 1 0000ab/5e", we_cnt - n_we, last_we_addr, last_we_data); end
        checks++; if (dl_wait !== 1'b0) begin failures++; $display("FAIL dlfall_release got=%b exp=0", dl_wait); end
    endtask

    task automatic test_timeout();
        int n_tv;
        // ack on the last allowed wait cycle completes normally
        do_reset();
        resp_en = 1'b1; ack_lo = ACK_TIMEOUT; ack_hi = ACK_TIMEOUT;
        mem_model[25'h000055] = 8'h5A;
        n_tv = tv_cnt;
        tp_req = 1'b1; tp_addr = 25'h000055; tick(); tp_req = 1'b0;
        for (int i = 0; i < 200 && tv_cnt == n_tv; i++) tick();
        checks++; if (last_tv_data !== 8'h5A || err !== 1'b0)
            begin failures++; $display("FAIL to_edge_ack data=%h err=%b exp 5a/0", last_tv_data, err); end
        checks++; if (last_tv_cyc !== last_rd_cyc + 1 + ACK_TIMEOUT)
            begin failures++; $display("FAIL to_edge_cycle got=%0d exp=%0d", last_tv_cyc, last_rd_cyc + 1 + ACK_TIMEOUT); end
        // one cycle later is too late: abort, zero byte, late ack ignored
        ack_lo = ACK_TIMEOUT + 1; ack_hi = ACK_TIMEOUT + 1;
        n_tv = tv_cnt;
        tp_req = 1'b1; tp_addr = 25'h000055; tick(); tp_req = 1'b0;
        for (int i = 0; i < 200 && tv_cnt == n_tv; i++) tick();
        checks++; if (last_tv_cyc !== last_rd_cyc + 1 + ACK_TIMEOUT)
            begin failures++; $display("FAIL to_rd_cycle got=%0d exp=%0d", last_tv_cyc, last_rd_cyc + 1 + ACK_TIMEOUT); end
        checks++; if (last_tv_data !== 8'h00) begin failures++; $display("FAIL to_rd_data got=%h exp=00", last_tv_data); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_set got=%b exp=1", err); end
        repeat (5) tick();
        checks++; if (tv_cnt - n_tv !== 1 || err !== 1'b1)
            begin failures++; $display("FAIL to_after tv=%0d err=%b exp 1/1", tv_cnt - n_tv, err); end
        // write timeout releases the loader
        resp_en = 1'b0;
        dl_wr = 1'b1; dl_addr = 25'h000066; dl_data = 8'h66; tick(); dl_wr = 1'b0;
        for (int i = 0; i < 200 && dl_wait; i++) tick();
        checks++; if (cyc !== last_we_cyc + 1 + ACK_TIMEOUT)
            begin failures++; $display("FAIL to_wr_release got=%0d exp=%0d", cyc, last_we_cyc + 1 + ACK_TIMEOUT); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid_access();
        int n_rd, n_tv;
        do_reset();
        resp_en = 1'b0;
        n_rd = rd_cnt;
        tp_req = 1'b1; tp_addr = 25'h0001C7; tick(); tp_req = 1'b0;
        for (int i = 0; i < 10 && rd_cnt == n_rd; i++) tick();
        tick(); tick();
        n_tv = tv_cnt;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({dl_wait, tp_valid, mem_we, mem_rd, err} !== 5'b0)
            begin failures++; $display("FAIL mrst_flags got=%b exp=00000", {dl_wait, tp_valid, mem_we, mem_rd, err}); end
        checks++; if ({tp_data, mem_addr, mem_din} !== 41'h0)
            begin failures++; $display("FAIL mrst_buses got=%h/%h/%h exp=0", tp_data, mem_addr, mem_din); end
        mem_ack = 1'b1; mem_dout = 8'h77;
        repeat (6) tick();
        checks++; if (tv_cnt !== n_tv) begin failures++; $display("FAIL mrst_no_valid got=%0d pulses exp=0", tv_cnt - n_tv); end
        resp_en = 1'b1; ack_lo = 2; ack_hi = 3;
        mem_model[25'h0001C8] = 8'hC8;
        tp_req = 1'b1; tp_addr = 25'h0001C8; tick(); tp_req = 1'b0;
        for (int i = 0; i < 30 && tv_cnt == n_tv; i++) tick();
        checks++; if (tv_cnt - n_tv !== 1 || last_tv_data !== 8'hC8)
            begin failures++; $display("FAIL mrst_new_read pulses=%0d data=%h exp 1/c8", tv_cnt - n_tv, last_tv_data); end
    endtask

    // Random traffic against a transaction-level model: every accepted write
    // and read is issued once, in order, reads only when downloads were idle,
    // and each read returns the memory contents at the time it was served.
    task automatic test_random();
        logic [32:0] wr_q[$];
        logic [24:0] rd_q[$];
        logic [7:0]  tv_q[$];
        logic [32:0] ew;
        logic [24:0] ea;
        logic [7:0]  ed;
        bit exp_wait, rd_busy, prev_dl_active;
        do_reset();
        resp_en = 1'b1; ack_lo = 1; ack_hi = 6;
        exp_wait = 1'b0; rd_busy = 1'b0; prev_dl_active = 1'b0;
        for (int i = 0; i < 800; i++) begin
            checks++; if (dl_wait !== exp_wait) begin failures++; $display("FAIL rnd_dl_wait cyc=%0d got=%b exp=%b", cyc, dl_wait, exp_wait); end
            checks++; if (mem_we && mem_rd) begin failures++; $display("FAIL rnd_both_strobes cyc=%0d got=11 exp=not both", cyc); end
            if (obs_we) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious_we cyc=%0d addr=%h exp=no write", cyc, mem_addr);
                end else begin
                    ew = wr_q.pop_front();
                    if ({mem_addr, mem_din} !== ew) begin failures++; $display("FAIL rnd_we_cmd cyc=%0d got=%h exp=%h", cyc, {mem_addr, mem_din}, ew); end
                end
            end
            if (obs_rd) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious_rd cyc=%0d addr=%h exp=no read", cyc, mem_addr);
                end else begin
                    ea = rd_q.pop_front();
                    if (mem_addr !== ea || prev_dl_active !== 1'b0) begin
                        failures++; $display("FAIL rnd_rd_cmd cyc=%0d got=%h dl_active_prev=%b exp=%h/0", cyc, mem_addr, prev_dl_active, ea);
                    end
                end
                tv_q.push_back(rd_mem(mem_addr));
            end
            if (obs_tv) begin
                checks++;
                if (tv_q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious_tv cyc=%0d data=%h exp=no pulse", cyc, tp_data);
                end else begin
                    ed = tv_q.pop_front();
                    if (tp_data !== ed || cyc !== last_rd_ack_cyc + 1) begin
                        failures++; $display("FAIL rnd_tv cyc=%0d got=%h exp=%h at %0d", cyc, tp_data, ed, last_rd_ack_cyc + 1);
                    end
                end
                rd_busy = 1'b0;
            end
            // drive the next cycle
            if (i < 600) begin
                if ($urandom_range(15, 0) == 0) dl_active = ~dl_active;
                dl_wr  = ($urandom_range(3, 0) == 0);
                tp_req = ($urandom_range(3, 0) == 0);
            end else begin
                dl_active = 1'b0; dl_wr = 1'b0; tp_req = 1'b0;
            end
            dl_addr = 25'($urandom_range(15, 0)); dl_data = 8'($urandom);
            tp_addr = 25'($urandom_range(15, 0));
            if (dl_wr && !dl_wait) begin
                wr_q.push_back({dl_addr, dl_data});
                exp_wait = 1'b1;
            end else if (ack_wr_now) begin
                exp_wait = 1'b0;
            end
            if (tp_req && !rd_busy) begin
                rd_q.push_back(tp_addr);
                rd_busy = 1'b1;
            end
            prev_dl_active = dl_active;
            tick();
        end
        checks++; if (wr_q.size() + rd_q.size() + tv_q.size() != 0)
            begin failures++; $display("FAIL rnd_drain left wr=%0d rd=%0d tv=%0d exp=0", wr_q.size(), rd_q.size(), tv_q.size()); end
    endtask

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        tp_req = 1'b0; tp_addr = '0; mem_dout = '0; mem_ack = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_gating();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
